// File: rtl/refresh_pkg.sv
// Shared types and default timings for the RAM refresh servicer.
package refresh_pkg;

  typedef enum logic [1:0] {IDLE, CAS, RAS, PRE} refState_t;

  localparam int unsigned T_CSR_DEF    = 1;
  localparam int unsigned T_RAS_DEF    = 3;
  localparam int unsigned T_RP_DEF     = 2;
  localparam int unsigned DEBT_W_DEF   = 2;
  localparam int unsigned DEBT_MAX_DEF = 3;

endpackage

// File: rtl/ram_refresh_servicer.sv
// Turns RefReq/RefUrg refresh windows into CAS-before-RAS refresh cycles,
// stalling the CPU under urgency and repaying missed windows as debt.
module ram_refresh_servicer
  import refresh_pkg::*;
#(
  parameter int unsigned T_CSR    = T_CSR_DEF,
  parameter int unsigned T_RAS    = T_RAS_DEF,
  parameter int unsigned T_RP     = T_RP_DEF,
  parameter int unsigned DEBT_W   = DEBT_W_DEF,
  parameter int unsigned DEBT_MAX = DEBT_MAX_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              RefReq,
  input  logic              RefUrg,
  input  logic              BACT,
  input  logic              RAMCS,
  input  logic              RAMBusy,
  output logic              RefStall,
  output logic              nCASref,
  output logic              nRASref,
  output logic              RefActive,
  output logic              RefStart,
  output logic              RefMiss,
  output logic [DEBT_W-1:0] Debt
);

  localparam logic [2:0]        csrInit = 3'(T_CSR - 1);
  localparam logic [2:0]        rasInit = 3'(T_RAS - 1);
  localparam logic [2:0]        rpInit  = 3'(T_RP - 1);
  localparam logic [DEBT_W-1:0] debtMax = DEBT_W'(DEBT_MAX);
  localparam logic [DEBT_W-1:0] debtOne = DEBT_W'(1);

  refState_t         stateQ, stateD;
  logic [2:0]        cntQ, cntD;
  logic              doneQ, doneD;
  logic [DEBT_W-1:0] debtQ, debtD;
  logic              stallQ, stallD;
  logic              nCasQ, nCasD;
  logic              nRasQ, nRasD;
  logic              refReqR;

  logic debtNz, pending, urgent, winClose, start, miss;

  assign debtNz   = debtQ != '0;
  assign pending  = !doneQ || debtNz;
  assign urgent   = pending && (RefUrg || debtNz);
  assign winClose = refReqR && !RefReq;
  // Urgent starts ignore the CPU cycle: RefStall is what keeps the CPU off RAM.
  assign start    = (stateQ == IDLE) && !RAMBusy &&
                    ((pending && !(BACT && RAMCS)) || urgent);
  assign miss     = winClose && !doneQ && !start;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      IDLE: begin
        if (start) begin
          stateD = CAS;
          cntD   = csrInit;
        end
      end
      CAS: begin
        if (cntQ == '0) begin
          stateD = RAS;
          cntD   = rasInit;
        end else begin
          cntD = cntQ - 3'd1;
        end
      end
      RAS: begin
        if (cntQ == '0) begin
          stateD = PRE;
          cntD   = rpInit;
        end else begin
          cntD = cntQ - 3'd1;
        end
      end
      PRE: begin
        if (cntQ == '0) stateD = IDLE;
        else            cntD   = cntQ - 3'd1;
      end
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    nCasD  = 1'b1;
    nRasD  = 1'b1;
    stallD = stallQ;
    doneD  = doneQ;
    debtD  = debtQ;
    if (stateD == CAS || stateD == RAS) nCasD = 1'b0;
    if (stateD == RAS) nRasD = 1'b0;
    // Stall is re-evaluated only in IDLE; a started refresh keeps whatever it had.
    if (stateQ == IDLE && !start) stallD = urgent;
    if (start) begin
      if (!doneQ) doneD = 1'b1;
      else        debtD = debtQ - debtOne;
    end
    if (miss && debtQ != debtMax) debtD = debtQ + debtOne;
    if (winClose) doneD = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      refReqR <= 1'b0;
      doneQ   <= 1'b0;
      debtQ   <= '0;
      stallQ  <= 1'b0;
      nCasQ   <= 1'b1;
      nRasQ   <= 1'b1;
    end else begin
      refReqR <= RefReq;
      doneQ   <= doneD;
      debtQ   <= debtD;
      stallQ  <= stallD;
      nCasQ   <= nCasD;
      nRasQ   <= nRasD;
    end
  end

  assign RefStall  = stallQ;
  assign nCASref   = nCasQ;
  assign nRASref   = nRasQ;
  assign RefActive = stateQ != IDLE;
  assign RefStart  = start;
  assign RefMiss   = miss;
  assign Debt      = debtQ;

endmodule
